// File: rtl/rs_flip_flop.sv
// WIDTH-bit clocked RS storage element with a configurable S=R=1 resolution
// policy, complementary outputs and a registered per-bit conflict flag.

module rs_flip_flop_bit #(
    parameter bit RESET_Q     = 1'b0,
    parameter int BOTH_POLICY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic err
);

    logic q_nxt;

    always_comb begin
        q_nxt = q;
        case ({s, r})
            2'b10: q_nxt = 1'b1;
            2'b01: q_nxt = 1'b0;
            2'b11: begin
                // Out-of-range policy values fall through to hold.
                case (BOTH_POLICY)
                    1:       q_nxt = 1'b1;
                    2:       q_nxt = 1'b0;
                    3:       q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RESET_Q;
            err <= 1'b0;
        end else begin
            q   <= q_nxt;
            err <= s & r;
        end
    end

endmodule

module rs_flip_flop #(
    parameter int WIDTH       = 1,
    parameter bit RESET_Q     = 1'b0,
    parameter int BOTH_POLICY = 0
) (
    input  logic [WIDTH-1:0] S_in,
    input  logic [WIDTH-1:0] R_in,
    input  logic             CLK_in,
    output logic [WIDTH-1:0] Q_out,
    output logic [WIDTH-1:0] QB_out,
    // Defaults low so five-port positional instances still elaborate.
    input  logic             RST_in = 1'b0,
    output logic [WIDTH-1:0] ERR_out
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            rs_flip_flop_bit #(
                .RESET_Q    (RESET_Q),
                .BOTH_POLICY(BOTH_POLICY)
            ) u_bit (
                .clk(CLK_in),
                .rst(RST_in),
                .s  (S_in[i]),
                .r  (R_in[i]),
                .q  (Q_out[i]),
                .err(ERR_out[i])
            );
        end
    endgenerate

    assign QB_out = ~Q_out;

endmodule

// File: tb/tb_rs_flip_flop.sv
// Bench for rs_flip_flop: five 4-bit instances covering every S=R=1 policy and
// both reset values, driven in lockstep and compared to a per-bit rule model.

module tb_rs_flip_flop;

    localparam int N = 5;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s, r;
    logic [W-1:0] q[N], qb[N], err[N];

    int n_assert = 0;
    int n_fail   = 0;

    // Instance configuration: policy and reset value.
    int pol[N] = '{0, 1, 2, 3, 3};
    int rq[N]  = '{0, 0, 0, 0, 1};

    // Model state: one int per bit per instance.
    int mq[N][W];
    int merr[N][W];

    always #5 clk = ~clk;

    rs_flip_flop #(.WIDTH(W), .RESET_Q(1'b0), .BOTH_POLICY(0)) u0 (
        .S_in(s), .R_in(r), .CLK_in(clk), .Q_out(q[0]), .QB_out(qb[0]), .RST_in(rst), .ERR_out(err[0]));
    rs_flip_flop #(.WIDTH(W), .RESET_Q(1'b0), .BOTH_POLICY(1)) u1 (
        .S_in(s), .R_in(r), .CLK_in(clk), .Q_out(q[1]), .QB_out(qb[1]), .RST_in(rst), .ERR_out(err[1]));
    rs_flip_flop #(.WIDTH(W), .RESET_Q(1'b0), .BOTH_POLICY(2)) u2 (
        .S_in(s), .R_in(r), .CLK_in(clk), .Q_out(q[2]), .QB_out(qb[2]), .RST_in(rst), .ERR_out(err[2]));
    rs_flip_flop #(.WIDTH(W), .RESET_Q(1'b0), .BOTH_POLICY(3)) u3 (
        .S_in(s), .R_in(r), .CLK_in(clk), .Q_out(q[3]), .QB_out(qb[3]), .RST_in(rst), .ERR_out(err[3]));
    rs_flip_flop #(.WIDTH(W), .RESET_Q(1'b1), .BOTH_POLICY(3)) u4 (
        .S_in(s), .R_in(r), .CLK_in(clk), .Q_out(q[4]), .QB_out(qb[4]), .RST_in(rst), .ERR_out(err[4]));

    // Apply one clock edge of the rules to the model.
    task automatic model_edge(input logic [W-1:0] sv, input logic [W-1:0] rv, input bit rv_rst);
        for (int n = 0; n < N; n++) begin
            for (int k = 0; k < W; k++) begin
                if (rv_rst) begin
                    mq[n][k]   = rq[n];
                    merr[n][k] = 0;
                end else begin
                    merr[n][k] = (sv[k] && rv[k]) ? 1 : 0;
                    if (sv[k] && !rv[k])      mq[n][k] = 1;
                    else if (!sv[k] && rv[k]) mq[n][k] = 0;
                    else if (sv[k] && rv[k]) begin
                        if (pol[n] == 1)      mq[n][k] = 1;
                        else if (pol[n] == 2) mq[n][k] = 0;
                        else if (pol[n] == 3) mq[n][k] = 1 - mq[n][k];
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic [W-1:0] eq, ee;
        for (int n = 0; n < N; n++) begin
            for (int k = 0; k < W; k++) begin
                eq[k] = (mq[n][k] != 0);
                ee[k] = (merr[n][k] != 0);
            end
            n_assert++;
            assert (q[n] === eq) else begin
                n_fail++;
                $error("FAIL %s q[%0d]: observed %b expected %b", tag, n, q[n], eq);
            end
            n_assert++;
            assert (qb[n] === ~eq) else begin
                n_fail++;
                $error("FAIL %s qb[%0d]: observed %b expected %b", tag, n, qb[n], ~eq);
            end
            n_assert++;
            assert (err[n] === ee) else begin
                n_fail++;
                $error("FAIL %s err[%0d]: observed %b expected %b", tag, n, err[n], ee);
            end
        end
    endtask

    task automatic step(input logic [W-1:0] sv, input logic [W-1:0] rv, input bit rv_rst, input string tag);
        @(negedge clk);
        s = sv; r = rv; rst = rv_rst;
        @(posedge clk);
        #1;
        model_edge(sv, rv, rv_rst);
        check(tag);
    endtask

    // S pulses high only between edges; no edge sees it.
    task automatic pulse_between(input string tag);
        @(negedge clk);
        s = '1; r = '0; rst = 1'b0;
        #2;
        s = '0;
        @(posedge clk);
        #1;
        model_edge('0, '0, 1'b0);
        check(tag);
    endtask

    initial begin
        s = '1; r = '0; rst = 1'b1;

        step(4'hF, 4'h0, 1'b1, "reset1");
        step(4'hF, 4'h0, 1'b1, "reset2");
        step(4'hF, 4'h0, 1'b0, "set_after_rst");

        // Basic sequence, each condition held several edges.
        repeat (3) step(4'hF, 4'h0, 1'b0, "set");
        repeat (3) step(4'hF, 4'hF, 1'b0, "both_from1");
        repeat (3) step(4'h0, 4'hF, 1'b0, "reset_req");
        repeat (3) step(4'hF, 4'hF, 1'b0, "both_from0");
        repeat (3) step(4'h0, 4'h0, 1'b0, "idle");

        // Policies from Q=0 over three edges.
        step(4'h0, 4'hF, 1'b0, "clear");
        repeat (3) step(4'hF, 4'hF, 1'b0, "policy");

        // Edge sampling.
        step(4'h0, 4'hF, 1'b0, "clear2");
        pulse_between("pulse_ignored");
        step(4'hF, 4'h0, 1'b0, "set_one_edge");

        // Reset priority with set/reset requests active.
        step(4'hF, 4'h0, 1'b1, "rst_over_set");
        step(4'h0, 4'hF, 1'b1, "rst_over_reset");

        // Mixed per-bit pattern from Q=0.
        step(4'h0, 4'hF, 1'b0, "clear3");
        step(4'b1010, 4'b0110, 1'b0, "mixed");

        // Random traffic with occasional reset.
        for (int t = 0; t < 300; t++) begin
            step(W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
